// File: rtl/cache_sim_pkg.sv
// Shared types and defaults for the cache request arbiter.
package cache_sim_pkg;

    localparam int unsigned ADDR_W_DEF   = 31;
    localparam int unsigned CNT_W_DEF    = 31;
    localparam int unsigned MISS_LAT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_MISS_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_e;

    // Requester id: 0 or 1.
    typedef logic port_id_t;

    // One-hot select for a requester id.
    function automatic logic [1:0] port_onehot(port_id_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Requester and cache-lookup handshake bundle for cache_req_arbiter.
// master: requesters plus cache model; slave: the arbiter.
interface cache_req_arbiter_if #(
    parameter int unsigned ADDR_W = cache_sim_pkg::ADDR_W_DEF
);

    logic              req0_41;
    logic              req1_41;
    logic [ADDR_W-1:0] addr0_41;
    logic [ADDR_W-1:0] addr1_41;
    logic              gnt0_41;
    logic              gnt1_41;
    logic              resp0_41;
    logic              resp1_41;
    logic              hit_41;
    logic              lk_valid_41;
    logic [ADDR_W-1:0] lk_addr_41;
    logic              lk_ready_41;
    logic              lk_hit_41;

    modport master (
        output req0_41, req1_41, addr0_41, addr1_41, lk_ready_41, lk_hit_41,
        input  gnt0_41, gnt1_41, resp0_41, resp1_41, hit_41, lk_valid_41, lk_addr_41
    );

    modport slave (
        input  req0_41, req1_41, addr0_41, addr1_41, lk_ready_41, lk_hit_41,
        output gnt0_41, gnt1_41, resp0_41, resp1_41, hit_41, lk_valid_41, lk_addr_41
    );

endinterface

// File: rtl/cache_arb_rr2.sv
// Two-way round-robin grant: on a tie the port not served last wins.
// Until something has been served (last_vld low) port 0 wins ties.
module cache_arb_rr2
    import cache_sim_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last,
    input  logic       last_vld,
    output logic [1:0] gnt_c
);

    // one-hot winner selection
    always_comb begin
        gnt_c = 2'b00;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (!last_vld || last) ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Two-port cache lookup arbiter: grants one requester at a time, runs the
// lookup handshake, models miss latency and returns a one-cycle response.
// Optional per-port hit/miss statistics are built when CACHE_ARB_STATS_EN
// is defined; otherwise the counter outputs are tied to zero.
module cache_req_arbiter
    import cache_sim_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned MISS_LAT = MISS_LAT_DEF
) (
    input  logic               clk_41,
    input  logic               rst_41,
    cache_req_arbiter_if.slave bus,
    output logic               busy_41,
    output logic [CNT_W-1:0]   hits0_41,
    output logic [CNT_W-1:0]   hits1_41,
    output logic [CNT_W-1:0]   misses0_41,
    output logic [CNT_W-1:0]   misses1_41
);

    localparam logic [1:0] IDLE      = ST_IDLE;
    localparam logic [1:0] LOOKUP    = ST_LOOKUP;
    localparam logic [1:0] MISS_WAIT = ST_MISS_WAIT;
    localparam logic [1:0] RESP      = ST_RESP;

    localparam int unsigned MW = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    logic [1:0]        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        resp_q, resp_d;
    logic              hit_q, hit_d;
    logic              lk_valid_q, lk_valid_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    port_id_t          port_q, port_d;
    port_id_t          last_q, last_d;
    logic              last_vld_q, last_vld_d;
    logic [MW-1:0]     mcnt_q, mcnt_d;

    logic [1:0]        rr_gnt_c;
    port_id_t          rr_last_c;
    logic              rr_vld_c;

    // In RESP the pointer is about to become the served port, so arbitrate with it now
    assign rr_last_c = (state_q == RESP) ? port_q : last_q;
    assign rr_vld_c  = (state_q == RESP) | last_vld_q;

    cache_arb_rr2 u_rr (
        .req      ({bus.req1_41, bus.req0_41}),
        .last     (rr_last_c),
        .last_vld (rr_vld_c),
        .gnt_c    (rr_gnt_c)
    );

    // next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = 2'b00;
        resp_d     = 2'b00;
        hit_d      = hit_q;
        lk_valid_d = 1'b0;
        addr_d     = addr_q;
        port_d     = port_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        mcnt_d     = mcnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_q != 2'b00) begin
                    state_d    = LOOKUP;
                    lk_valid_d = 1'b1;
                end else if (rr_gnt_c != 2'b00) begin
                    gnt_d  = rr_gnt_c;
                    port_d = rr_gnt_c[1];
                    addr_d = rr_gnt_c[1] ? bus.addr1_41 : bus.addr0_41;
                end
            end
            LOOKUP: begin
                lk_valid_d = 1'b1;
                if (bus.lk_ready_41) begin
                    lk_valid_d = 1'b0;
                    hit_d      = bus.lk_hit_41;
                    if (bus.lk_hit_41 || (MISS_LAT == 0)) begin
                        state_d = RESP;
                        resp_d  = port_onehot(port_q);
                    end else begin
                        state_d = MISS_WAIT;
                        mcnt_d  = MW'(MISS_LAT - 1);
                    end
                end
            end
            MISS_WAIT: begin
                if (mcnt_q == '0) begin
                    state_d = RESP;
                    resp_d  = port_onehot(port_q);
                end else begin
                    mcnt_d = mcnt_q - MW'(1);
                end
            end
            RESP: begin
                state_d    = IDLE;
                last_d     = port_q;
                last_vld_d = 1'b1;
                if (rr_gnt_c != 2'b00) begin
                    gnt_d  = rr_gnt_c;
                    port_d = rr_gnt_c[1];
                    addr_d = rr_gnt_c[1] ? bus.addr1_41 : bus.addr0_41;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and registered outputs, synchronous active-low reset
    always_ff @(posedge clk_41) begin
        if (!rst_41) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            resp_q     <= 2'b00;
            hit_q      <= 1'b0;
            lk_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            port_q     <= 1'b0;
            last_q     <= 1'b0;
            last_vld_q <= 1'b0;
            mcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            resp_q     <= resp_d;
            hit_q      <= hit_d;
            lk_valid_q <= lk_valid_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            port_q     <= port_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            mcnt_q     <= mcnt_d;
        end
    end

    assign bus.gnt0_41     = gnt_q[0];
    assign bus.gnt1_41     = gnt_q[1];
    assign bus.resp0_41    = resp_q[0];
    assign bus.resp1_41    = resp_q[1];
    assign bus.hit_41      = hit_q;
    assign bus.lk_valid_41 = lk_valid_q;
    assign bus.lk_addr_41  = addr_q;
    assign busy_41         = busy_q;

`ifdef CACHE_ARB_STATS_EN
    logic [CNT_W-1:0] hits0_q, hits1_q, misses0_q, misses1_q;

    // saturating per-port hit/miss counters, bumped in the RESP cycle
    always_ff @(posedge clk_41) begin
        if (!rst_41) begin
            hits0_q   <= '0;
            hits1_q   <= '0;
            misses0_q <= '0;
            misses1_q <= '0;
        end else if (state_q == RESP) begin
            if (hit_q) begin
                if (!port_q && (hits0_q != '1))   hits0_q   <= hits0_q + CNT_W'(1);
                if (port_q && (hits1_q != '1))    hits1_q   <= hits1_q + CNT_W'(1);
            end else begin
                if (!port_q && (misses0_q != '1)) misses0_q <= misses0_q + CNT_W'(1);
                if (port_q && (misses1_q != '1))  misses1_q <= misses1_q + CNT_W'(1);
            end
        end
    end

    assign hits0_41   = hits0_q;
    assign hits1_41   = hits1_q;
    assign misses0_41 = misses0_q;
    assign misses1_41 = misses1_q;
`else
    assign hits0_41   = '0;
    assign hits1_41   = '0;
    assign misses0_41 = '0;
    assign misses1_41 = '0;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction model.
module tb_cache_req_arbiter;
    import cache_sim_pkg::*;

    localparam int unsigned AW  = 31;
    localparam int unsigned CW  = 3;
    localparam int unsigned ML  = 8;
    localparam int          SAT = (1 << CW) - 1;
`ifdef CACHE_ARB_STATS_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic          clk_41 = 1'b0;
    logic          rst_41;
    logic          busy_41;
    logic [CW-1:0] hits0_41, hits1_41, misses0_41, misses1_41;

    cache_req_arbiter_if #(.ADDR_W(AW)) bus ();

    cache_req_arbiter #(.ADDR_W(AW), .CNT_W(CW), .MISS_LAT(ML)) dut (
        .clk_41     (clk_41),
        .rst_41     (rst_41),
        .bus        (bus),
        .busy_41    (busy_41),
        .hits0_41   (hits0_41),
        .hits1_41   (hits1_41),
        .misses0_41 (misses0_41),
        .misses1_41 (misses1_41)
    );

    always #5 clk_41 = ~clk_41;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int stat(input int x);
        return STAT_ON ? x : 0;
    endfunction

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int          port;
        bit          hit;
        int          d;       // cycles of lk_ready delay inside LOOKUP
        int          gnt_c;   // cycle of gnt pulse
        int          resp_c;  // cycle of resp pulse
        logic [AW-1:0] addr;
    } txn_t;

    txn_t q[$];
    int   cyc, free_at, prio;
    int   cnt_h[2], cnt_m[2];

    bit            req_v[2];
    logic [AW-1:0] addr_v[2];
    bit            rst_v;
    bit            rand_plan, plan_hit, spur_en, auto_drop, rand_req;
    int            plan_d;

    int obs_gnt_cyc[$], obs_gnt_port[$], obs_resp_cyc[$], obs_resp_port[$];
    bit obs_resp_hit[$];

    task automatic obs_clear();
        obs_gnt_cyc.delete(); obs_gnt_port.delete();
        obs_resp_cyc.delete(); obs_resp_port.delete(); obs_resp_hit.delete();
    endtask

    function automatic bit pending(input int p);
        foreach (q[i]) if (q[i].port == p && q[i].gnt_c >= cyc) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive inputs, advance the model, compare at negedge.
    task automatic step();
        txn_t t;
        bit rdy, lkh, in_win;
        bit e_g[2], e_r[2];
        bit e_lkv, e_busy, e_hit;
        logic [AW-1:0] e_addr;
        int e_cnt[4];
        int p, d;
        bit h;
        @(posedge clk_41);
        #1;
        cyc++;
        while (q.size() != 0 && q[0].resp_c < cyc) begin
            t = q.pop_front();
            if (t.hit) cnt_h[t.port] = (cnt_h[t.port] < SAT) ? cnt_h[t.port] + 1 : SAT;
            else       cnt_m[t.port] = (cnt_m[t.port] < SAT) ? cnt_m[t.port] + 1 : SAT;
        end
        if (auto_drop) foreach (q[i]) if (q[i].gnt_c == cyc - 1) req_v[q[i].port] = 1'b0;
        if (rand_req) begin
            for (int k = 0; k < 2; k++) begin
                if (!req_v[k] && $urandom_range(0, 2) == 0) begin
                    req_v[k]  = 1'b1;
                    addr_v[k] = AW'($urandom());
                end else if (req_v[k] && !pending(k) && $urandom_range(0, 11) == 0) begin
                    req_v[k] = 1'b0;
                end
            end
            rst_v = ($urandom_range(0, 399) != 0);
        end
        rst_41       = rst_v;
        bus.req0_41  = req_v[0];
        bus.req1_41  = req_v[1];
        bus.addr0_41 = addr_v[0];
        bus.addr1_41 = addr_v[1];

        // cache model response and expected outputs for this cycle
        rdy = 1'b0; lkh = 1'b0; in_win = 1'b0;
        e_g[0] = 0; e_g[1] = 0; e_r[0] = 0; e_r[1] = 0;
        e_lkv = 0; e_busy = 0; e_hit = 0; e_addr = '0;
        foreach (q[i]) begin
            if (cyc == q[i].gnt_c + 1 + q[i].d) begin rdy = 1'b1; lkh = q[i].hit; end
            else if (cyc > q[i].gnt_c && cyc < q[i].gnt_c + 1 + q[i].d) in_win = 1'b1;
            if (cyc == q[i].gnt_c) e_g[q[i].port] = 1'b1;
            if (cyc > q[i].gnt_c && cyc <= q[i].gnt_c + 1 + q[i].d) begin
                e_lkv = 1'b1; e_addr = q[i].addr;
            end
            if (cyc == q[i].resp_c) begin e_r[q[i].port] = 1'b1; e_hit = q[i].hit; end
            if (cyc > q[i].gnt_c && cyc <= q[i].resp_c) e_busy = 1'b1;
        end
        if (!rdy && !in_win && spur_en) begin
            rdy = ($urandom_range(0, 3) == 0);
            lkh = $urandom_range(0, 1) == 1;
        end
        bus.lk_ready_41 = rdy;
        bus.lk_hit_41   = lkh;
        e_cnt[0] = cnt_h[0]; e_cnt[1] = cnt_h[1]; e_cnt[2] = cnt_m[0]; e_cnt[3] = cnt_m[1];

        if (!rst_v) begin
            q.delete();
            cnt_h[0] = 0; cnt_h[1] = 0; cnt_m[0] = 0; cnt_m[1] = 0;
            prio = 0;
            free_at = cyc + 1;
        end else if (cyc >= free_at && (req_v[0] || req_v[1])) begin
            p = (req_v[0] && req_v[1]) ? prio : (req_v[1] ? 1 : 0);
            d = rand_plan ? $urandom_range(0, 3) : plan_d;
            h = rand_plan ? ($urandom_range(0, 1) == 1) : plan_hit;
            t.port = p; t.hit = h; t.d = d; t.addr = addr_v[p];
            t.gnt_c  = cyc + 1;
            t.resp_c = cyc + 3 + d + (h ? 0 : ML);
            free_at  = t.resp_c;
            prio     = 1 - p;
            q.push_back(t);
        end

        @(negedge clk_41);
        chk("gnt0", bus.gnt0_41, e_g[0]);
        chk("gnt1", bus.gnt1_41, e_g[1]);
        chk("resp0", bus.resp0_41, e_r[0]);
        chk("resp1", bus.resp1_41, e_r[1]);
        chk("lk_valid", bus.lk_valid_41, e_lkv);
        chk("busy", busy_41, e_busy);
        if (e_lkv) chk("lk_addr", bus.lk_addr_41, e_addr);
        if (e_r[0] || e_r[1]) chk("hit", bus.hit_41, e_hit);
        chk("hits0", hits0_41, stat(e_cnt[0]));
        chk("hits1", hits1_41, stat(e_cnt[1]));
        chk("misses0", misses0_41, stat(e_cnt[2]));
        chk("misses1", misses1_41, stat(e_cnt[3]));
        if (bus.gnt0_41 || bus.gnt1_41) begin
            obs_gnt_cyc.push_back(cyc); obs_gnt_port.push_back(bus.gnt1_41 ? 1 : 0);
        end
        if (bus.resp0_41 || bus.resp1_41) begin
            obs_resp_cyc.push_back(cyc); obs_resp_port.push_back(bus.resp1_41 ? 1 : 0);
            obs_resp_hit.push_back(bus.hit_41);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int port; bit hit; int d; int lat;
        int h0; int h1; int m0; int m1;
    } vec_t;

    vec_t vt[12];

    initial begin
        int n;
        vt[0] = '{0, 1'b1, 0, 2,  1, 0, 0, 0};
        vt[1] = '{1, 1'b0, 0, 10, 1, 0, 0, 1};
        vt[2] = '{0, 1'b1, 3, 5,  2, 0, 0, 1};
        vt[3] = '{1, 1'b1, 1, 3,  2, 1, 0, 1};
        vt[4] = '{0, 1'b0, 2, 12, 2, 1, 1, 1};
        for (int i = 5; i < 12; i++) vt[i] = '{0, 1'b1, 0, 2, (i - 2 > SAT) ? SAT : i - 2, 1, 1, 1};

        req_v[0] = 0; req_v[1] = 0; addr_v[0] = '0; addr_v[1] = '0;
        rand_plan = 0; plan_hit = 1; plan_d = 0; spur_en = 0; auto_drop = 1; rand_req = 0;
        cyc = 0; free_at = 0; prio = 0;
        cnt_h[0] = 0; cnt_h[1] = 0; cnt_m[0] = 0; cnt_m[1] = 0;
        rst_v = 0;
        rst_41 = 0;
        bus.req0_41 = 0; bus.req1_41 = 0; bus.addr0_41 = '0; bus.addr1_41 = '0;
        bus.lk_ready_41 = 0; bus.lk_hit_41 = 0;
        repeat (2) @(posedge clk_41);
        step();
        chk("reset lk_addr", bus.lk_addr_41, 0);
        chk("reset hit", bus.hit_41, 0);
        rst_v = 1;
        step();

        // table-driven single-port transactions
        for (int i = 0; i < 12; i++) begin
            plan_d = vt[i].d; plan_hit = vt[i].hit;
            req_v[vt[i].port]  = 1'b1;
            addr_v[vt[i].port] = AW'($urandom());
            obs_clear();
            n = 0;
            while (obs_resp_cyc.size() == 0 && n < 40) begin step(); n++; end
            if (obs_resp_cyc.size() == 0 || obs_gnt_cyc.size() == 0) begin
                chk("vec resp timeout", 0, 1);
            end else begin
                chk("vec latency", obs_resp_cyc[0] - obs_gnt_cyc[0], vt[i].lat);
                chk("vec gnt port", obs_gnt_port[0], vt[i].port);
                chk("vec resp port", obs_resp_port[0], vt[i].port);
                chk("vec hit", obs_resp_hit[0], vt[i].hit);
            end
            step();
            chk("vec hits0", hits0_41, stat(vt[i].h0));
            chk("vec hits1", hits1_41, stat(vt[i].h1));
            chk("vec misses0", misses0_41, stat(vt[i].m0));
            chk("vec misses1", misses1_41, stat(vt[i].m1));
            step();
        end

        // reset during MISS_WAIT aborts the transaction
        plan_d = 0; plan_hit = 0;
        req_v[1] = 1'b1; addr_v[1] = AW'($urandom());
        obs_clear();
        n = 0;
        while (obs_gnt_cyc.size() == 0 && n < 10) begin step(); n++; end
        chk("rst-test grant seen", obs_gnt_cyc.size(), 1);
        repeat (3) step();
        chk("rst-test busy before reset", busy_41, 1);
        rst_v = 0;
        step();
        rst_v = 1;
        step();
        chk("rst-test busy", busy_41, 0);
        chk("rst-test resp1", bus.resp1_41, 0);
        chk("rst-test counters", {hits0_41, hits1_41, misses0_41, misses1_41}, 0);
        repeat (15) step();
        chk("rst-test no resp", obs_resp_cyc.size(), 0);

        // both requests held: alternating grants starting with port 0
        rst_v = 0; step(); rst_v = 1;
        auto_drop = 0; plan_d = 0; plan_hit = 1;
        req_v[0] = 1'b1; req_v[1] = 1'b1;
        addr_v[0] = AW'($urandom()); addr_v[1] = AW'($urandom());
        obs_clear();
        n = 0;
        while ((obs_gnt_cyc.size() < 4 || obs_resp_cyc.size() < 4) && n < 60) begin step(); n++; end
        if (obs_gnt_cyc.size() < 4 || obs_resp_cyc.size() < 4) begin
            chk("rr timeout", 0, 1);
        end else begin
            for (int k = 0; k < 4; k++) begin
                chk("rr gnt order", obs_gnt_port[k], k % 2);
                chk("rr resp order", obs_resp_port[k], k % 2);
            end
            for (int k = 0; k < 3; k++) chk("rr resp-to-next-gnt", obs_gnt_cyc[k + 1] - obs_resp_cyc[k], 1);
        end
        req_v[0] = 0; req_v[1] = 0; auto_drop = 1;
        repeat (6) step();

        // randomized traffic against the model
        rand_plan = 1; spur_en = 1; rand_req = 1;
        repeat (3000) step();
        rand_req = 0; rst_v = 1; req_v[0] = 0; req_v[1] = 0; spur_en = 0;
        repeat (20) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
